// File: rtl/rgb_pkg.sv
// Shared definitions for the VGA capture/display path: state encodings
// compared by the display stage, and the default source/destination geometry.
package rgb_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WAIT_SOF = 4'd1,
        ST_CAPTURE  = 4'd2,
        ST_DONE     = 4'd3
    } main_state_e;

    localparam int SRC_W_DEF      = 640;
    localparam int SRC_H_DEF      = 480;
    localparam int DECIM_DEF      = 10;
    localparam int DST_W_DEF      = 64;
    localparam int DST_H_DEF      = 48;
    localparam int NUM_FRAMES_DEF = 6;
    localparam int ADDR_W_DEF     = 15;
    localparam int FRAME_PIXELS   = 3072;

endpackage

// File: rtl/decim_counter.sv
// Mod-DECIM phase counter. restart_i makes the current pixel phase 0,
// clr_i forces the next phase to 0, adv_i steps it; zero_o reports phase 0.
module decim_counter #(
    parameter int DECIM = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic restart_i,
    input  logic adv_i,
    input  logic clr_i,
    output logic zero_o
);
    localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CW-1:0] LAST = CW'(DECIM - 1);

    logic [CW-1:0] cnt_q, cnt_d, cnt_c;

    always_comb begin
        cnt_c = restart_i ? '0 : cnt_q;
        cnt_d = cnt_c;
        if (clr_i)
            cnt_d = '0;
        else if (adv_i)
            cnt_d = (cnt_c == LAST) ? '0 : cnt_c + 1'b1;
    end

    assign zero_o = (cnt_c == '0);

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/frame_capture.sv
// Decimating frame grabber: keeps every DECIM-th pixel of every DECIM-th line
// and writes it into a multi-frame buffer, one write per kept pixel.
module frame_capture
    import rgb_pkg::*;
#(
    parameter int SRC_W      = SRC_W_DEF,
    parameter int SRC_H      = SRC_H_DEF,
    parameter int DECIM      = DECIM_DEF,
    parameter int DST_W      = DST_W_DEF,
    parameter int DST_H      = DST_H_DEF,
    parameter int NUM_FRAMES = NUM_FRAMES_DEF,
    parameter int ADDR_W     = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pix_valid,
    input  logic [15:0]       pix_data,
    input  logic              pix_sof,
    input  logic              pix_eol,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic [3:0]        main_state,
    output logic [2:0]        frame_idx
);
    localparam int DX_W = $clog2(SRC_W / DECIM + 1);
    localparam int DY_W = $clog2(SRC_H / DECIM + 1);
    localparam int LN_W = $clog2(SRC_H + 1);
    localparam logic [DX_W-1:0]   DX_LIM     = DX_W'(DST_W);
    localparam logic [DY_W-1:0]   DY_LIM     = DY_W'(DST_H);
    localparam logic [LN_W-1:0]   LN_LAST    = LN_W'(SRC_H - 1);
    localparam logic [2:0]        FI_LAST    = 3'(NUM_FRAMES - 1);
    localparam logic [ADDR_W-1:0] LINE_STEP  = ADDR_W'(DST_W);
    localparam logic [ADDR_W-1:0] FRAME_STEP = ADDR_W'(DST_W * DST_H);

    main_state_e       state_q, state_d;
    logic [2:0]        frame_idx_q, frame_idx_d;
    logic [ADDR_W-1:0] frame_base_q, frame_base_d, line_base_q, line_base_d, lb_c;
    logic [DX_W-1:0]   dx_q, dx_d, dx_c;
    logic [DY_W-1:0]   dy_q, dy_d, dy_c;
    logic [LN_W-1:0]   line_q, line_d, line_c;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic              accept, restart, go, x_zero, y_zero, keep, frame_end;

    decim_counter #(.DECIM(DECIM)) u_px (
        .clk(clk), .reset(reset), .restart_i(restart),
        .adv_i(accept & ~pix_eol), .clr_i((accept & pix_eol) | go), .zero_o(x_zero)
    );

    decim_counter #(.DECIM(DECIM)) u_py (
        .clk(clk), .reset(reset), .restart_i(restart),
        .adv_i(accept & pix_eol), .clr_i(frame_end | go), .zero_o(y_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_WAIT_SOF;
            ST_WAIT_SOF:      if (accept) state_d = ST_CAPTURE;
            ST_CAPTURE:       if (frame_end) state_d = (frame_idx_q == FI_LAST) ? ST_DONE : ST_WAIT_SOF;
            default:          state_d = ST_IDLE;
        endcase
    end

    // A sof pixel is accepted in WAIT_SOF and CAPTURE alike and always restarts the frame.
    always_comb begin
        accept  = 1'b0;
        restart = 1'b0;
        go      = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: go = start;
            ST_WAIT_SOF: begin
                accept  = pix_valid & pix_sof;
                restart = pix_valid & pix_sof;
            end
            ST_CAPTURE: begin
                accept  = pix_valid;
                restart = pix_valid & pix_sof;
            end
            default: ;
        endcase
    end

    always_comb begin
        dx_c      = restart ? '0 : dx_q;
        dy_c      = restart ? '0 : dy_q;
        line_c    = restart ? '0 : line_q;
        lb_c      = restart ? '0 : line_base_q;
        frame_end = accept & pix_eol & (line_c == LN_LAST);
        keep      = accept & x_zero & y_zero & (dx_c < DX_LIM) & (dy_c < DY_LIM);

        wr_en_d      = keep;
        wr_addr_d    = keep ? frame_base_q + lb_c + ADDR_W'(dx_c) : wr_addr_q;
        wr_data_d    = keep ? pix_data : wr_data_q;
        frame_idx_d  = frame_idx_q;
        frame_base_d = frame_base_q;
        line_base_d  = line_base_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        line_d       = line_q;

        if (go) begin
            frame_idx_d  = '0;
            frame_base_d = '0;
            line_base_d  = '0;
            dx_d         = '0;
            dy_d         = '0;
            line_d       = '0;
        end else if (accept) begin
            dx_d        = dx_c;
            dy_d        = dy_c;
            line_d      = line_c;
            line_base_d = lb_c;
            // dx/dy saturate at the destination size so overlong lines/frames write nothing.
            if (pix_eol) begin
                dx_d   = '0;
                line_d = line_c + 1'b1;
                if (y_zero && (dy_c < DY_LIM)) begin
                    dy_d        = dy_c + 1'b1;
                    line_base_d = lb_c + LINE_STEP;
                end
            end else if (x_zero && (dx_c < DX_LIM)) begin
                dx_d = dx_c + 1'b1;
            end
            if (frame_end) begin
                dx_d        = '0;
                dy_d        = '0;
                line_d      = '0;
                line_base_d = '0;
                if (frame_idx_q != FI_LAST) begin
                    frame_idx_d  = frame_idx_q + 1'b1;
                    frame_base_d = frame_base_q + FRAME_STEP;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_idx_q  <= '0;
            frame_base_q <= '0;
            line_base_q  <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            line_q       <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            frame_idx_q  <= frame_idx_d;
            frame_base_q <= frame_base_d;
            line_base_q  <= line_base_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            line_q       <= line_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign main_state = state_q;
    assign frame_idx  = frame_idx_q;
endmodule

// File: tb/tb_frame_capture.sv
// Directed bench for frame_capture on a scaled 32x24 source, decimation 4 (8x6 per frame, 6 frames).
module tb_frame_capture;
    localparam int SW = 32, SH = 24, DC = 4, DW = 8, DH = 6, NF = 6, AW = 15;
    localparam int FP = DW * DH;

    logic          clk = 1'b0;
    logic          reset, start, pix_valid, pix_sof, pix_eol;
    logic [15:0]   pix_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic [3:0]    main_state;
    logic [2:0]    frame_idx;

    frame_capture #(
        .SRC_W(SW), .SRC_H(SH), .DECIM(DC), .DST_W(DW), .DST_H(DH),
        .NUM_FRAMES(NF), .ADDR_W(AW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .pix_valid(pix_valid),
        .pix_data(pix_data), .pix_sof(pix_sof), .pix_eol(pix_eol),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .main_state(main_state), .frame_idx(frame_idx)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0, n_bad = 0;
    int          wr_cnt = 0, first_addr = -1, last_addr = -1, max_addr = 0, base = 0;
    bit          mark = 1'b0;
    logic [15:0] mem [0:FP*NF-1];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    // Source data is {y,x}, so each write's data is implied by its address.
    always @(negedge clk) begin : mon
        int a;
        if (wr_en === 1'b1) begin
            a = int'(wr_addr);
            wr_cnt++;
            last_addr = a;
            if (mark) begin first_addr = a; mark = 1'b0; end
            if (a > max_addr) max_addr = a;
            chk("wr_in_range", a < FP*NF, 1);
            chk("wr_frame", a / FP, frame_idx);
            chk("wr_state", main_state, 2);
            chk("wr_data", wr_data, {8'(((a % FP) / DW) * DC), 8'((a % DW) * DC)});
            mem[a % (FP*NF)] = wr_data;
        end
    end

    task automatic pix(input int x, input int y, input bit sof, input bit eol);
        @(negedge clk);
        pix_valid = 1'b1; pix_sof = sof; pix_eol = eol;
        pix_data = {y[7:0], x[7:0]};
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pix_valid = 1'b0; pix_sof = 1'b0; pix_eol = 1'b0;
        end
    endtask

    task automatic frame(input int w, input int y0, input int y1, input bit gaps);
        for (int y = y0; y < y1; y++)
            for (int x = 0; x < w; x++) begin
                if (gaps && $urandom_range(0, 3) == 0) idle(1 + $urandom_range(0, 1));
                pix(x, y, (x == 0) && (y == 0), x == w - 1);
            end
        idle(1);
    endtask

    task automatic pulse_start;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; pix_eol = 1'b0; pix_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_state", main_state, 0);
        chk("rst_fidx", frame_idx, 0);
        @(negedge clk) reset = 1'b0;

        pulse_start;
        chk("start_idle", main_state, 1);
        for (int i = 0; i < 10; i++) pix(i, 5, 1'b0, i == 9);
        idle(3);
        chk("wait_sof_nowr", wr_cnt, 0);
        chk("wait_sof_state", main_state, 1);

        mark = 1'b1;
        frame(SW, 0, SH, 1'b0);
        chk("f0_state", main_state, 1);
        chk("f0_fidx", frame_idx, 1);
        chk("f0_first", first_addr, 0);
        chk("f0_last", last_addr, 47);
        chk("f0_count", wr_cnt, FP);
        chk("f0_px_4_8", mem[17], 16'h0804);
        idle(20);
        chk("gap_nowr", wr_cnt, FP);

        for (int f = 1; f < NF; f++) begin
            chk("fidx_step", frame_idx, f);
            if (f == 5) mark = 1'b1;
            if (f == 3) begin
                frame(SW, 0, 5, 1'b1);
                pulse_start;
                chk("start_cap_state", main_state, 2);
                chk("start_cap_fidx", frame_idx, 3);
                frame(SW, 5, SH, 1'b1);
            end else begin
                frame(SW, 0, SH, 1'b1);
            end
        end
        chk("done_state", main_state, 3);
        chk("done_fidx", frame_idx, 5);
        chk("f5_first", first_addr, 240);
        chk("f5_last", last_addr, 287);
        chk("six_count", wr_cnt, FP * NF);
        idle(5);
        chk("done_hold", main_state, 3);

        pulse_start;
        chk("restart_state", main_state, 1);
        chk("restart_fidx", frame_idx, 0);
        mark = 1'b1; base = wr_cnt;
        frame(SW, 0, SH, 1'b1);
        chk("restart_first", first_addr, 0);
        chk("restart_count", wr_cnt - base, FP);
        frame(SW, 0, SH, 1'b0);

        base = wr_cnt;
        frame(SW, 0, 12, 1'b1);
        chk("f2_partial", wr_cnt - base, 24);
        mark = 1'b1;
        frame(SW, 0, SH, 1'b1);
        chk("sof_restart_addr", first_addr, 96);
        chk("sof_restart_cnt", wr_cnt - base, 72);
        chk("sof_restart_state", main_state, 1);
        chk("sof_restart_fidx", frame_idx, 3);

        base = wr_cnt; max_addr = 0;
        frame(SW + 4, 0, SH + 2, 1'b1);
        chk("big_count", wr_cnt - base, FP);
        chk("big_max", max_addr, 191);
        chk("big_last", last_addr, 191);
        chk("big_fidx", frame_idx, 4);

        frame(SW, 0, 4, 1'b0);
        base = wr_cnt;
        @(negedge clk);
        pix_valid = 1'b1; pix_sof = 1'b0; pix_eol = 1'b0; pix_data = 16'h0400; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; pix_valid = 1'b0;
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_wr_addr", wr_addr, 0);
        chk("mid_rst_wr_data", wr_data, 0);
        chk("mid_rst_state", main_state, 0);
        chk("mid_rst_fidx", frame_idx, 0);
        pix(0, 0, 1'b1, 1'b0);
        idle(2);
        chk("idle_ignores", wr_cnt - base, 0);
        chk("idle_state", main_state, 0);

        pulse_start;
        mark = 1'b1; base = wr_cnt;
        frame(SW, 0, SH, 1'b0);
        chk("post_rst_first", first_addr, 0);
        chk("post_rst_last", last_addr, 47);
        chk("post_rst_count", wr_cnt - base, FP);
        chk("post_rst_px_4_8", mem[17], 16'h0804);
        chk("post_rst_px_28_20", mem[47], 16'h141C);
        chk("post_rst_fidx", frame_idx, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
